// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, data-memory
// freezes with a sticky wait timeout, and stall/flush performance counters.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  logic        memread_ex,
  input  logic [4:0]  rd_ex,
  input  logic        branch_taken_ex,
  input  logic        dmem_req_mem,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        mem_wb_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_timeout
);
  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;

  state_t      r_state;
  logic [1:0]  r_init_cnt;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        r_timeout;

  logic w_init, w_mem_stall, w_load_use, w_branch_flush;
  logic [6:0] w_ctl;

  // reset is folded in so outputs show the INIT pattern while it is held
  assign w_init      = reset | (r_state == INIT);
  assign w_mem_stall = dmem_req_mem & ~dmem_ready;
  assign w_load_use  = memread_ex & (rd_ex != 5'd0) &
                       ((use_rs1_id & (rs1_id == rd_ex)) | (use_rs2_id & (rs2_id == rd_ex)));
  assign w_branch_flush = ~w_init & ~w_mem_stall & branch_taken_ex;

  // {pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_flush, id_ex_flush}
  always_comb begin
    w_ctl = 7'b1111100;
    if (w_init)              w_ctl = 7'b0111111;
    else if (w_mem_stall)    w_ctl = 7'b0000000;
    else if (branch_taken_ex) w_ctl = 7'b1111111;
    else if (w_load_use)     w_ctl = 7'b0011101;
  end

  assign {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
          if_id_flush, id_ex_flush} = w_ctl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= INIT;
      r_init_cnt  <= 2'd0;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          if (r_init_cnt == 2'd1) begin
            r_state    <= RUN;
            r_init_cnt <= 2'd0;
          end else begin
            r_init_cnt <= r_init_cnt + 2'd1;
          end
        end
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          // ready or a dropped request both end the wait; timeout never aborts it
          if (!w_mem_stall) begin
            r_state <= RUN;
          end else if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_wait_cnt == 8'hFE) r_timeout <= 1'b1;
          end
        end
        default: r_state <= INIT;
      endcase

      if (r_state != INIT) begin
        if (!pc_write && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
        if (w_branch_flush && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign mem_timeout = r_timeout;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: cycle-level reference model checked on every
// negedge, plus literal expectations for the key scenarios.
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic        use_rs1_id = 0, use_rs2_id = 0, memread_ex = 0;
  logic        branch_taken_ex = 0, dmem_req_mem = 0, dmem_ready = 0;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic        if_id_flush, id_ex_flush, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .memread_ex(memread_ex),
    .rd_ex(rd_ex), .branch_taken_ex(branch_taken_ex), .dmem_req_mem(dmem_req_mem),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  wire [6:0] ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                    if_id_flush, id_ex_flush};

  // Reference model: cycles left in INIT, length of the current memory-stall run,
  // sticky timeout, and plain integer counters.
  int   m_init = 2, m_streak = 0, m_stall = 0, m_flush = 0;
  logic m_to = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic ms, lu, stall_now, flush_now;
      logic [6:0] e;
      ms = dmem_req_mem && !dmem_ready;
      lu = memread_ex && rd_ex != 0 &&
           ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));
      stall_now = 0; flush_now = 0;
      if (reset || m_init > 0) e = 7'b0111111;
      else if (ms) begin e = 7'b0000000; stall_now = 1; end
      else if (branch_taken_ex) begin e = 7'b1111111; flush_now = 1; end
      else if (lu) begin e = 7'b0011101; stall_now = 1; end
      else e = 7'b1111100;
      chk("ctl", {25'd0, ctl}, {25'd0, e});
      chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
      chk("flush_cnt", {16'd0, flush_cnt}, m_flush);
      chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
      if (reset) begin
        m_init = 2; m_streak = 0; m_stall = 0; m_flush = 0; m_to = 0;
      end else if (m_init > 0) begin
        m_init--; m_streak = 0;
      end else begin
        // run of N consecutive stall cycles: wait counter reaches 255 on cycle 256
        m_streak = ms ? m_streak + 1 : 0;
        if (m_streak >= 256) m_to = 1;
        if (stall_now && m_stall < 16'hFFFF) m_stall++;
        if (flush_now && m_flush < 16'hFFFF) m_flush++;
      end
    end
  end

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, br, req, rdy;
  } vec_t;

  task automatic drive(input vec_t v);
    rs1_id = v.rs1; rs2_id = v.rs2; rd_ex = v.rd;
    use_rs1_id = v.u1; use_rs2_id = v.u2; memread_ex = v.mr;
    branch_taken_ex = v.br; dmem_req_mem = v.req; dmem_ready = v.rdy;
  endtask

  task automatic half(); @(negedge clk); #1; endtask
  task automatic fin();  @(posedge clk); #1; endtask

  localparam vec_t IDLE = '{rs1:5'd0, rs2:5'd0, rd:5'd0, u1:0, u2:0, mr:0, br:0, req:0, rdy:0};

  vec_t tbl [0:9];

  initial begin
    tbl[0] = '{rs1:5'd7, rs2:5'd1, rd:5'd7, u1:1, u2:0, mr:1, br:0, req:0, rdy:0};
    tbl[1] = '{rs1:5'd7, rs2:5'd1, rd:5'd7, u1:0, u2:0, mr:1, br:0, req:0, rdy:0};
    tbl[2] = '{rs1:5'd7, rs2:5'd7, rd:5'd7, u1:1, u2:1, mr:0, br:0, req:0, rdy:0};
    tbl[3] = '{rs1:5'd3, rs2:5'd3, rd:5'd3, u1:1, u2:1, mr:1, br:1, req:1, rdy:0};
    tbl[4] = '{rs1:5'd3, rs2:5'd3, rd:5'd3, u1:1, u2:1, mr:1, br:1, req:1, rdy:0};
    tbl[5] = '{rs1:5'd0, rs2:5'd0, rd:5'd0, u1:0, u2:0, mr:0, br:0, req:0, rdy:0};
    tbl[6] = '{rs1:5'd9, rs2:5'd2, rd:5'd9, u1:1, u2:1, mr:1, br:0, req:1, rdy:1};
    tbl[7] = '{rs1:5'd31, rs2:5'd4, rd:5'd31, u1:1, u2:0, mr:1, br:0, req:0, rdy:1};
    tbl[8] = '{rs1:5'd1, rs2:5'd2, rd:5'd3, u1:1, u2:1, mr:1, br:1, req:0, rdy:0};
    tbl[9] = '{rs1:5'd6, rs2:5'd6, rd:5'd6, u1:0, u2:1, mr:1, br:0, req:1, rdy:1};

    drive(IDLE);
    reset = 1;
    fin();
    chk_en = 1;
    half(); fin();
    half(); fin();

    // reset release: two INIT cycles with pc_write=0, then normal
    reset = 0;
    half(); chk("init1_pc", {31'd0, pc_write}, 0); fin();
    half(); chk("init2_pc", {31'd0, pc_write}, 0); fin();
    half();
    chk("run_ctl", {25'd0, ctl}, 32'h7C);
    chk("run_stall0", {16'd0, stall_cnt}, 0);
    chk("run_flush0", {16'd0, flush_cnt}, 0);
    fin();

    // load-use on rs2
    drive('{rs1:5'd0, rs2:5'd5, rd:5'd5, u1:0, u2:1, mr:1, br:0, req:0, rdy:0});
    half();
    chk("lu_ctl", {25'd0, ctl}, 32'h1D);
    fin();
    drive(IDLE);
    half(); chk("lu_stall_cnt", {16'd0, stall_cnt}, 1); fin();

    // rd_ex = 0 never stalls
    drive('{rs1:5'd0, rs2:5'd0, rd:5'd0, u1:0, u2:1, mr:1, br:0, req:0, rdy:0});
    half(); chk("rd0_pc", {31'd0, pc_write}, 1); fin();
    drive(IDLE);
    half(); chk("rd0_stall_cnt", {16'd0, stall_cnt}, 1); fin();

    // branch overrides load-use
    drive('{rs1:5'd0, rs2:5'd5, rd:5'd5, u1:0, u2:1, mr:1, br:1, req:0, rdy:0});
    half(); chk("br_ctl", {25'd0, ctl}, 32'h7F); fin();
    drive(IDLE);
    half();
    chk("br_flush_cnt", {16'd0, flush_cnt}, 1);
    chk("br_stall_cnt", {16'd0, stall_cnt}, 1);
    fin();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i]); half(); fin();
    end

    // memory freeze: reset first so the stall count starts from zero
    drive(IDLE);
    reset = 1; half(); fin();
    reset = 0; half(); fin(); half(); fin();
    dmem_req_mem = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      half(); chk("memw_ctl", {25'd0, ctl}, 0); fin();
    end
    dmem_ready = 1;
    half(); chk("memw_resume", {25'd0, ctl}, 32'h7C); fin();
    drive(IDLE);
    half(); chk("memw_stall_cnt", {16'd0, stall_cnt}, 3); fin();

    // long wait: timeout visible once the wait counter has reached 255
    dmem_req_mem = 1; dmem_ready = 0;
    for (int i = 1; i <= 300; i++) begin
      half();
      if (i == 256) chk("to_before", {31'd0, mem_timeout}, 0);
      if (i == 257) chk("to_set", {31'd0, mem_timeout}, 1);
      fin();
    end

    // reset mid-wait, request still stalling: INIT pattern, no freeze
    reset = 1;
    half(); chk("rst_ctl", {25'd0, ctl}, 32'h3F); fin();
    reset = 0;
    half();
    chk("rst_to", {31'd0, mem_timeout}, 0);
    chk("rst_init_ctl", {25'd0, ctl}, 32'h3F);
    fin();
    half(); fin();
    drive(IDLE);
    half(); chk("rst_run_ctl", {25'd0, ctl}, 32'h7C); fin();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk, reset, reset synchronous, active-high; clock clk.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- rs1_id, rs2_id  in  5 each  source regs of the instruction in ID
- use_rs1_id, use_rs2_id  in  1 each  ID instruction reads rs1/rs2
- memread_ex  in  1  EX instruction is a load
- rd_ex  in  5  destination reg of the EX instruction
- branch_taken_ex  in  1  branch/jump resolved taken in EX
- dmem_req_mem  in  1  MEM-stage data memory access active
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  stage-register load enables
- if_id_flush, id_ex_flush  out  1 each  load zeros (bubble) at next edge
- stall_cnt, flush_cnt  out  16 each  performance counters
- mem_timeout  out  1  sticky memory-wait timeout

Function
REQ-002 SHALL implement FSM states INIT, RUN, MEM_WAIT, with 2-bit init counter and 8-bit wait counter.
REQ-003 INIT SHALL last exactly 2 cycles, driving pc_write=0, if_id_flush=1, id_ex_flush=1, and all other write enables 1, then move to RUN.
REQ-004 mem_stall = dmem_req_mem & ~dmem_ready, evaluated combinationally in RUN and MEM_WAIT.
REQ-005 If mem_stall, all five write enables SHALL be 0 and both flushes SHALL be 0 (full freeze), overriding every other condition.
REQ-006 RUN -> MEM_WAIT when mem_stall; MEM_WAIT -> RUN in the cycle dmem_ready=1, and that cycle SHALL use normal RUN output evaluation.
REQ-007 If not mem_stall and branch_taken_ex=1, outputs SHALL be pc_write=1, all write enables 1, if_id_flush=1, id_ex_flush=1, and load-use detection SHALL be ignored.
REQ-008 Load-use SHALL be memread_ex & rd_ex!=0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
REQ-009 If load-use holds and neither higher-priority condition holds, outputs SHALL be pc_write=0, if_id_write=0, id_ex_flush=1, and id_ex_write/ex_mem_write/mem_wb_write=1.
REQ-010 Otherwise outputs SHALL be all write enables 1 and both flushes 0.
REQ-011 Priority SHALL be: INIT > mem_stall > branch flush > load-use > normal.
REQ-012 stall_cnt SHALL increment by 1, saturating at 0xFFFF, each RUN/MEM_WAIT cycle with pc_write=0.
REQ-013 flush_cnt SHALL increment by 1, saturating at 0xFFFF, each cycle REQ-007 applies.
REQ-014 wait_cnt SHALL clear on entering MEM_WAIT and increment each MEM_WAIT cycle with mem_stall.
REQ-015 When wait_cnt reaches 255, mem_timeout SHALL set and remain 1 until reset; the FSM SHALL stay in MEM_WAIT and wait_cnt SHALL hold at 255.
REQ-016 If dmem_req_mem drops while in MEM_WAIT, the FSM SHALL return to RUN.

Reset
REQ-017 reset SHALL be sampled on clk rising edge and take priority over all other logic.
REQ-018 On reset: state=INIT, init counter=0, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
REQ-019 While reset=1 and in the first INIT cycle, outputs SHALL follow REQ-003.
REQ-020 Reset asserted mid-MEM_WAIT or mid-stall SHALL return to INIT with no residual stall.

Verification
REQ-021 The bench SHALL cover: reset release -> pc_write=0 for exactly 2 cycles, then all enables 1, and counters 0.
REQ-022 The bench SHALL cover: memread_ex=1, rd_ex=5, rs2_id=5, use_rs2_id=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, and stall_cnt=1.
REQ-023 The bench SHALL cover: same load-use with rd_ex=0 -> no stall.
REQ-024 The bench SHALL cover: branch_taken_ex=1 together with load-use -> both flushes 1, pc_write=1, flush_cnt=1, and stall_cnt unchanged.
REQ-025 The bench SHALL cover: dmem_req_mem=1 with dmem_ready low for 3 cycles -> all enables 0 for 3 cycles, then dmem_ready=1 resumes, and stall_cnt=3.
REQ-026 The bench SHALL cover: dmem_ready held low for 300 cycles -> mem_timeout=1 from the wait cycle 255 onward, and reset clears mem_timeout to 0.
